dma_mem_responder: RTL and testbench

- Memory-side responder for the simplified DMA memory interface. It services single-beat 64-bit read and write requests from dma_controller against an internal word-addressed SRAM.
- Returns a one-cycle mem_ready pulse after a programmable latency, so DMA WAIT_READ/WAIT_WRITE paths can be exercised with realistic timing.
- Used as the on-chip scratchpad behind the DMA and as the standard bench memory model.
- Flags address range, alignment and protocol errors. It never hangs the initiator.

---
 rtl/dma_pkg.sv | 25 ++
 rtl/dma_sp_sram.sv | 36 +++
 rtl/dma_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_dma_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the simplified DMA memory interface.
package dma_pkg;

  localparam int unsigned DMA_ADDR_W     = 32;
  localparam int unsigned DMA_DATA_W     = 64;
  localparam int unsigned DMA_BEAT_BYTES = 8;

  // err_status bit indices
  localparam int unsigned ERR_RANGE    = 0;
  localparam int unsigned ERR_MISALIGN = 1;
  localparam int unsigned ERR_PROTO    = 2;
  localparam int unsigned ERR_W        = 3;

  typedef enum logic [1:0] {
    RESP_IDLE    = 2'd0,
    RESP_BUSY_RD = 2'd1,
    RESP_BUSY_WR = 2'd2
  } resp_state_t;

  // True when a byte address is not on a beat boundary.
  function automatic logic beat_misaligned(input logic [DMA_ADDR_W-1:0] addr);
    return addr[2:0] != 3'd0;
  endfunction

endpackage

// File: rtl/dma_sp_sram.sv
// Single-port SRAM: synchronous write, synchronous read into an output register.
module dma_sp_sram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Output register only changes on a read so it holds between accesses.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  // Array write and read-data register; contents have no reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dma_mem_responder.sv
// Memory-side responder for the DMA: single-beat reads/writes against an
// internal scratchpad with programmable completion latency and sticky errors.
module dma_mem_responder
  import dma_pkg::*;
#(
  parameter int unsigned          DEPTH_WORDS   = 1024,
  parameter logic [DMA_ADDR_W-1:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned          READ_LATENCY  = 2,
  parameter int unsigned          WRITE_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
  input  logic [DMA_ADDR_W-1:0] mem_read_addr,
  input  logic [DMA_ADDR_W-1:0] mem_write_addr,
  input  logic [DMA_DATA_W-1:0] mem_write_data,
  output logic [DMA_DATA_W-1:0] mem_read_data,
  output logic                  mem_ready,
  output logic [ERR_W-1:0]      err_status,
  input  logic                  err_clear,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
  localparam int unsigned LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [DMA_ADDR_W:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'(DMA_BEAT_BYTES);

  resp_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              oor_q, oor_d;
  logic              ready_q, ready_d;
  logic              rd_zero_q, rd_zero_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [15:0]       rd_count_q, rd_count_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic [ERR_W-1:0]      new_err;
  logic                  sram_we, sram_re;
  logic [IDX_W-1:0]      sram_addr;
  logic [DMA_DATA_W-1:0] sram_rdata;

  logic [DMA_ADDR_W-1:0] req_addr;
  logic [DMA_ADDR_W:0]   req_off;
  logic                  req_in_range;
  logic [IDX_W-1:0]      req_idx;

  // Request decode: write address wins when both enables are high.
  always_comb begin
    req_addr     = mem_write_en ? mem_write_addr : mem_read_addr;
    req_off      = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    req_in_range = !req_off[DMA_ADDR_W] && (req_off < SPAN_BYTES);
    req_idx      = IDX_W'(req_off >> 3);
  end

  // Next-state, latency counter, SRAM control, counters and error flags.
  // The array read is issued in the cycle before mem_ready so its output
  // register presents the word exactly in the ready cycle; no write can
  // intervene because only one request is ever outstanding.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    oor_d      = oor_q;
    ready_d    = 1'b0;
    rd_zero_d  = rd_zero_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    new_err    = '0;
    sram_we    = 1'b0;
    sram_re    = 1'b0;
    sram_addr  = idx_q;

    case (state_q)
      RESP_IDLE: begin
        if (mem_write_en || mem_read_en) begin
          idx_d                  = req_idx;
          oor_d                  = !req_in_range;
          sram_addr              = req_idx;
          new_err[ERR_RANGE]     = !req_in_range;
          new_err[ERR_MISALIGN]  = beat_misaligned(req_addr);
          new_err[ERR_PROTO]     = mem_write_en && mem_read_en;
          if (mem_write_en) begin
            state_d = RESP_BUSY_WR;
            cnt_d   = CNT_W'(WRITE_LATENCY - 1);
            sram_we = req_in_range;
            if (WRITE_LATENCY == 1) begin
              ready_d    = 1'b1;
              wr_count_d = wr_count_q + 16'd1;
            end
          end else begin
            state_d = RESP_BUSY_RD;
            cnt_d   = CNT_W'(READ_LATENCY - 1);
            if (READ_LATENCY == 1) begin
              ready_d    = 1'b1;
              rd_count_d = rd_count_q + 16'd1;
              sram_re    = req_in_range;
              rd_zero_d  = !req_in_range;
            end
          end
        end
      end
      RESP_BUSY_RD, RESP_BUSY_WR: begin
        new_err[ERR_PROTO] = mem_read_en || mem_write_en;
        if (cnt_q == '0) begin
          state_d = RESP_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            ready_d = 1'b1;
            if (state_q == RESP_BUSY_RD) begin
              rd_count_d = rd_count_q + 16'd1;
              sram_re    = !oor_q;
              rd_zero_d  = oor_q;
            end else begin
              wr_count_d = wr_count_q + 16'd1;
            end
          end
        end
      end
      default: state_d = RESP_IDLE;
    endcase

    err_d = err_clear ? new_err : (err_q | new_err);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RESP_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      oor_q      <= 1'b0;
      ready_q    <= 1'b0;
      rd_zero_q  <= 1'b1;
      err_q      <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      oor_q      <= oor_d;
      ready_q    <= ready_d;
      rd_zero_q  <= rd_zero_d;
      err_q      <= err_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  dma_sp_sram #(
    .DEPTH (DEPTH_WORDS),
    .WIDTH (DMA_DATA_W)
  ) u_sram (
    .clock (clock),
    .we    (sram_we && !reset),
    .re    (sram_re && !reset),
    .addr  (sram_addr),
    .wdata (mem_write_data),
    .rdata (sram_rdata)
  );

  // Read data is the SRAM output register, blanked after reset and for
  // out-of-range reads; both sources only change in a read's ready cycle.
  assign mem_read_data = rd_zero_q ? '0 : sram_rdata;
  assign mem_ready     = ready_q;
  assign err_status    = err_q;
  assign rd_count      = rd_count_q;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder: default-latency instance plus
// READ_LATENCY=1 and READ_LATENCY=4 instances for the latency sweep.
module tb_dma_mem_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        rd_en, wr_en, err_clear;
  logic [31:0] rd_addr, wr_addr;
  logic [63:0] wr_data;
  logic [63:0] rd_data;
  logic        ready;
  logic [2:0]  err;
  logic [15:0] rdc, wrc;

  logic        s_rd, s_wr;
  logic [31:0] s_addr;
  logic [63:0] s_wdata;
  logic [63:0] data1, data4;
  logic        ready1, ready4;
  logic [2:0]  err1, err4;
  logic [15:0] rdc1, wrc1, rdc4, wrc4;

  int checks = 0;
  int errors = 0;

  dma_mem_responder u_dut (
    .clock(clock), .reset(reset),
    .mem_read_en(rd_en), .mem_write_en(wr_en),
    .mem_read_addr(rd_addr), .mem_write_addr(wr_addr), .mem_write_data(wr_data),
    .mem_read_data(rd_data), .mem_ready(ready), .err_status(err), .err_clear(err_clear),
    .rd_count(rdc), .wr_count(wrc)
  );

  dma_mem_responder #(.READ_LATENCY(1)) u_rl1 (
    .clock(clock), .reset(reset),
    .mem_read_en(s_rd), .mem_write_en(s_wr),
    .mem_read_addr(s_addr), .mem_write_addr(s_addr), .mem_write_data(s_wdata),
    .mem_read_data(data1), .mem_ready(ready1), .err_status(err1), .err_clear(1'b0),
    .rd_count(rdc1), .wr_count(wrc1)
  );

  dma_mem_responder #(.READ_LATENCY(4)) u_rl4 (
    .clock(clock), .reset(reset),
    .mem_read_en(s_rd), .mem_write_en(s_wr),
    .mem_read_addr(s_addr), .mem_write_addr(s_addr), .mem_write_data(s_wdata),
    .mem_read_data(data4), .mem_ready(ready4), .err_status(err4), .err_clear(1'b0),
    .rd_count(rdc4), .wr_count(wrc4)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request for one cycle; returns one cycle after the request.
  task automatic req(input logic r, input logic w, input logic [31:0] ra,
                     input logic [31:0] wa, input logic [63:0] wd);
    rd_en = r; wr_en = w; rd_addr = ra; wr_addr = wa; wr_data = wd;
    tick;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  // Called one cycle after a request; stops in the ready cycle.
  task automatic wait_ready(input string tag, input int exp_lat);
    int n = 1;
    while (ready !== 1'b1 && n < 16) begin
      tick;
      n++;
    end
    chk(tag, 64'(n), 64'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pat [4];
    logic [63:0] buffer;
    int h1, h4, f1, f4;
    pat[0] = 64'h0123_4567_89AB_CDEF;
    pat[1] = 64'hFEDC_BA98_7654_3210;
    pat[2] = 64'h1111_2222_3333_4444;
    pat[3] = 64'h5555_6666_7777_8888;

    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; err_clear = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    s_rd = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = '0;
    tick; tick; tick;
    reset = 1'b0;
    chk("reset ready", 64'(ready), 64'd0);
    chk("reset data", rd_data, 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset rdc", 64'(rdc), 64'd0);
    chk("reset wrc", 64'(wrc), 64'd0);

    // Write then read at defaults
    req(1'b0, 1'b1, 32'h0, 32'h100, 64'hA5A5_0000_1234_5678);
    chk("wr ready T+1", 64'(ready), 64'd1);
    chk("wr count", 64'(wrc), 64'd1);
    tick;
    chk("wr ready pulse", 64'(ready), 64'd0);
    tick;
    req(1'b1, 1'b0, 32'h100, 32'h0, 64'h0);
    chk("rd not ready T+1", 64'(ready), 64'd0);
    tick;
    chk("rd ready T+2", 64'(ready), 64'd1);
    chk("rd data", rd_data, 64'hA5A5_0000_1234_5678);
    chk("rd count", 64'(rdc), 64'd1);
    chk("rd err", 64'(err), 64'd0);
    tick;
    chk("rd ready pulse", 64'(ready), 64'd0);
    chk("rd data hold", rd_data, 64'hA5A5_0000_1234_5678);

    // Out-of-range read
    req(1'b1, 1'b0, 32'h2000, 32'h0, 64'h0);
    chk("oor not ready T+1", 64'(ready), 64'd0);
    chk("oor err", 64'(err), 64'd1);
    tick;
    chk("oor ready", 64'(ready), 64'd1);
    chk("oor data", rd_data, 64'd0);
    chk("oor rd count", 64'(rdc), 64'd2);
    tick;
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    chk("err cleared", 64'(err), 64'd0);

    // Misaligned write, aligned read of containing word
    req(1'b0, 1'b1, 32'h0, 32'h10C, 64'h1);
    chk("mis ready", 64'(ready), 64'd1);
    chk("mis err", 64'(err), 64'd2);
    tick;
    req(1'b1, 1'b0, 32'h108, 32'h0, 64'h0);
    wait_ready("mis rd latency", 2);
    chk("mis rd data", rd_data, 64'h1);
    chk("mis err sticky", 64'(err), 64'd2);
    tick;
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;

    // Read and write together: write wins, read dropped
    req(1'b1, 1'b1, 32'h200, 32'h200, 64'hDEAD_BEEF_CAFE_F00D);
    chk("both ready", 64'(ready), 64'd1);
    chk("both err", 64'(err), 64'd4);
    chk("both wrc", 64'(wrc), 64'd3);
    tick;
    chk("both no extra T+2", 64'(ready), 64'd0);
    chk("both rdc", 64'(rdc), 64'd3);
    tick;
    chk("both no extra T+3", 64'(ready), 64'd0);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    req(1'b1, 1'b0, 32'h200, 32'h0, 64'h0);
    wait_ready("both rd latency", 2);
    chk("both committed", rd_data, 64'hDEAD_BEEF_CAFE_F00D);
    tick;

    // Second read while busy
    req(1'b1, 1'b0, 32'h100, 32'h0, 64'h0);
    rd_en = 1'b1; rd_addr = 32'h200;
    tick;
    rd_en = 1'b0;
    chk("busy rd ready", 64'(ready), 64'd1);
    chk("busy rd data", rd_data, 64'hA5A5_0000_1234_5678);
    tick;
    chk("busy no extra T+3", 64'(ready), 64'd0);
    chk("busy err", 64'(err), 64'd4);
    tick;
    chk("busy no extra T+4", 64'(ready), 64'd0);
    chk("busy rdc", 64'(rdc), 64'd5);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;

    // 2D loopback: seed source, reset counters (memory kept), copy
    for (int i = 0; i < 4; i++) begin
      req(1'b0, 1'b1, 32'h0, 32'((i / 2) * 32'h40 + (i % 2) * 8), pat[i]);
      tick;
    end
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    chk("lb reset rdc", 64'(rdc), 64'd0);
    chk("lb reset wrc", 64'(wrc), 64'd0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        req(1'b1, 1'b0, 32'(r * 32'h40 + c * 8), 32'h0, 64'h0);
        wait_ready("lb rd latency", 2);
        buffer = rd_data;
        tick;
        req(1'b0, 1'b1, 32'h0, 32'(32'h400 + r * 32'h80 + c * 8), buffer);
        chk("lb wr ready", 64'(ready), 64'd1);
        tick;
      end
    end
    chk("lb rdc", 64'(rdc), 64'd4);
    chk("lb wrc", 64'(wrc), 64'd4);
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 1'b0, 32'(32'h400 + (i / 2) * 32'h80 + (i % 2) * 8), 32'h0, 64'h0);
      wait_ready("lb verify latency", 2);
      chk("lb dst word", rd_data, pat[i]);
      tick;
    end

    // Reset mid-read: no mem_ready
    req(1'b1, 1'b0, 32'h400, 32'h0, 64'h0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("midrst ready T+2", 64'(ready), 64'd0);
    chk("midrst data", rd_data, 64'd0);
    tick;
    chk("midrst ready T+3", 64'(ready), 64'd0);
    chk("midrst rdc", 64'(rdc), 64'd0);

    // Latency sweep on READ_LATENCY=1 and 4 instances
    s_wr = 1'b1; s_addr = 32'h8; s_wdata = 64'hC0DE_0000_0000_0042;
    tick;
    s_wr = 1'b0;
    tick;
    s_rd = 1'b1;
    tick;
    s_rd = 1'b0;
    h1 = 0; h4 = 0; f1 = 0; f4 = 0;
    for (int i = 1; i <= 6; i++) begin
      if (ready1 === 1'b1) begin h1++; if (f1 == 0) f1 = i; end
      if (ready4 === 1'b1) begin h4++; if (f4 == 0) f4 = i; end
      tick;
    end
    chk("rl1 high cycles", 64'(h1), 64'd1);
    chk("rl1 latency", 64'(f1), 64'd1);
    chk("rl4 high cycles", 64'(h4), 64'd1);
    chk("rl4 latency", 64'(f4), 64'd4);
    chk("rl1 data", data1, 64'hC0DE_0000_0000_0042);
    chk("rl4 data", data4, 64'hC0DE_0000_0000_0042);
    chk("rl1 counts", {32'd0, rdc1, wrc1}, {32'd0, 16'd1, 16'd1});
    chk("rl4 counts", {32'd0, rdc4, wrc4}, {32'd0, 16'd1, 16'd1});
    chk("rl errs", 64'({err1, err4}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
